// File: rtl/spi_gen_pkg.sv
// Shared definitions for the generic SPI slave: FSM state encodings and the
// two-bit command codes carried at the head of every frame.
package spi_gen_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RECV     = 3'd1;
    localparam state_t ST_TX_WAIT  = 3'd2;
    localparam state_t ST_TX_SHIFT = 3'd3;
    localparam state_t ST_DONE     = 3'd4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_piso.sv
// Load-and-shift serialiser for the MISO path. The first bit appears on the
// load edge; each shift edge presents the next bit; otherwise the output idles at 0.
module spi_piso #(
    parameter int DATA_W    = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    output logic              miso
);

    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_d;
    logic              miso_q;
    logic              miso_d;

    // Next-bit selection; sh_q always holds the bits not yet presented.
    always_comb begin
        sh_d   = sh_q;
        miso_d = 1'b0;
        if (load) begin
            if (LSB_FIRST != 0) begin
                miso_d = data[0];
                sh_d   = data >> 1;
            end else begin
                miso_d = data[DATA_W-1];
                sh_d   = data << 1;
            end
        end else if (shift) begin
            if (LSB_FIRST != 0) begin
                miso_d = sh_q[0];
                sh_d   = sh_q >> 1;
            end else begin
                miso_d = sh_q[DATA_W-1];
                sh_d   = sh_q << 1;
            end
        end else begin
            miso_d = 1'b0;
        end
    end

    // Shift register and registered MISO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            miso_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            miso_q <= miso_d;
        end
    end

    assign miso = miso_q;

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave sampling SS_n/MOSI on clk: receives {cmd, payload} frames and
// answers read-data commands with tx_data serialised on MISO.
module spi_slave_gen
    import spi_gen_pkg::*;
#(
    parameter int PAY_W     = 8,
    parameter int DATA_W    = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [PAY_W+1:0]  rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              frame_abort,
    output logic              seq_err
);

    localparam int FRAME_W = PAY_W + 2;
    localparam int BW      = $clog2(FRAME_W + 1);
    localparam int TW      = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);
    localparam logic [TW-1:0] TX_LAST  = TW'(DATA_W);

    state_t               state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [FRAME_W-2:0]   rx_shift_q, rx_shift_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 abort_q, abort_d;
    logic                 seq_err_q, seq_err_d;
    logic                 rd_addr_seen_q, rd_addr_seen_d;
    logic                 piso_load_s;
    logic                 piso_shift_s;
    logic [FRAME_W-1:0]   frame_s;
    logic [1:0]           cmd_s;
    logic [PAY_W-1:0]     pay_s;

    assign frame_s = {rx_shift_q, MOSI};
    assign cmd_s   = frame_s[FRAME_W-1 -: 2];

    // The shifter always fills from the right, so LSB-first payloads are mirrored here.
    always_comb begin
        pay_s = frame_s[PAY_W-1:0];
        if (LSB_FIRST != 0) begin
            for (int i = 0; i < PAY_W; i++) begin
                pay_s[i] = frame_s[PAY_W-1-i];
            end
        end else begin
            pay_s = frame_s[PAY_W-1:0];
        end
    end

    // Frame FSM; SS_n high outranks frame completion on the same edge.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        tx_cnt_d       = tx_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rd_addr_seen_d = rd_addr_seen_q;
        rx_valid_d     = 1'b0;
        abort_d        = 1'b0;
        seq_err_d      = 1'b0;
        piso_load_s    = 1'b0;
        piso_shift_s   = 1'b0;
        if (SS_n && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
            abort_d   = ((state_q == ST_RECV) && (bit_cnt_q != '0)) ||
                        (state_q == ST_TX_WAIT) || (state_q == ST_TX_SHIFT);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!SS_n) begin
                        state_d   = ST_RECV;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RECV: begin
                    rx_shift_d = frame_s[FRAME_W-2:0];
                    bit_cnt_d  = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = {cmd_s, pay_s};
                        rx_valid_d = 1'b1;
                        case (cmd_s)
                            CMD_RD_DATA: begin
                                state_d        = ST_TX_WAIT;
                                seq_err_d      = !rd_addr_seen_q;
                                rd_addr_seen_d = 1'b0;
                            end
                            CMD_RD_ADDR: begin
                                state_d        = ST_DONE;
                                rd_addr_seen_d = 1'b1;
                            end
                            CMD_WR_ADDR, CMD_WR_DATA: state_d = ST_DONE;
                            default:                  state_d = ST_DONE;
                        endcase
                    end else begin
                        state_d = ST_RECV;
                    end
                end
                ST_TX_WAIT: begin
                    if (tx_valid) begin
                        piso_load_s = 1'b1;
                        tx_cnt_d    = TW'(1);
                        state_d     = ST_TX_SHIFT;
                    end else begin
                        state_d = ST_TX_WAIT;
                    end
                end
                ST_TX_SHIFT: begin
                    if (tx_cnt_q == TX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        piso_shift_s = 1'b1;
                        tx_cnt_d     = tx_cnt_q + TW'(1);
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            tx_cnt_q       <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            abort_q        <= 1'b0;
            seq_err_q      <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            tx_cnt_q       <= tx_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            abort_q        <= abort_d;
            seq_err_q      <= seq_err_d;
            rd_addr_seen_q <= rd_addr_seen_d;
        end
    end

    spi_piso #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (piso_load_s),
        .shift (piso_shift_s),
        .data  (tx_data),
        .miso  (MISO)
    );

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_abort = abort_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: a vector table of transactions with an rx scoreboard,
// plus hand-written abort, reset and LSB-first sequences.
module tb_spi_slave_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss_n = 1'b1, mosi = 1'b0, miso;
    logic [9:0] rx_data;
    logic       rx_valid, frame_abort, seq_err;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    logic       ss_l = 1'b1, mosi_l = 1'b0, miso_l;
    logic [9:0] rx_data_l;
    logic       rx_valid_l, abort_l, seq_err_l;
    logic [7:0] tx_data_l = 8'h00;
    logic       tx_valid_l = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [9:0] rx; logic seq; } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0] cmd; logic [7:0] pay; logic [7:0] tx; int dly;
        logic seq; logic [9:0] rx;
    } vec_t;
    vec_t vecs[7];

    spi_slave_gen #(.PAY_W(8), .DATA_W(8), .LSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .frame_abort(frame_abort), .seq_err(seq_err)
    );

    spi_slave_gen #(.PAY_W(8), .DATA_W(8), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .SS_n(ss_l), .MOSI(mosi_l), .MISO(miso_l),
        .rx_data(rx_data_l), .rx_valid(rx_valid_l), .tx_data(tx_data_l),
        .tx_valid(tx_valid_l), .frame_abort(abort_l), .seq_err(seq_err_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rx_valid must match the oldest pending frame.
    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            if (sb.size() == 0) begin
                chk("rx_valid_unexpected", {22'd0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rx_data", {22'd0, rx_data}, {22'd0, e.rx});
                chk("seq_err_with_valid", {31'd0, seq_err}, {31'd0, e.seq});
            end
        end
        if (!rst && seq_err && !rx_valid) chk("seq_err_alone", 32'd1, 32'd0);
    end

    task automatic run_txn(input logic [1:0] cmd, input logic [7:0] pay, input logic [7:0] tx,
                           input int dly, input logic exp_seq, input logic [9:0] exp_rx);
        logic [9:0] fr;
        logic [7:0] got;
        logic       miso_or;
        fr = {cmd, pay};
        sb.push_back('{exp_rx, exp_seq});
        miso_or = 1'b0;
        ss_n = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin
            mosi = fr[9-i]; tick(); miso_or |= miso;
            chk("abort_quiet", {31'd0, frame_abort}, 32'd0);
        end
        chk("rx_valid_after_last", {31'd0, rx_valid}, 32'd1);
        if (cmd == 2'b11) begin
            tx_data = tx;
            for (int d = 0; d < dly; d++) begin
                tick(); miso_or |= miso;
            end
            tx_valid = 1'b1; tick(); got[7] = miso; tx_valid = 1'b0;
            for (int j = 6; j >= 0; j--) begin
                tick(); got[j] = miso;
            end
            chk("miso_word", {24'd0, got}, {24'd0, tx});
            tick(); chk("miso_done_zero", {31'd0, miso}, 32'd0);
        end else begin
            tick(); miso_or |= miso;
            tick(); miso_or |= miso;
        end
        chk("miso_quiet", {31'd0, miso_or}, 32'd0);
        ss_n = 1'b1; tick();
        chk("no_abort_from_done", {31'd0, frame_abort}, 32'd0);
        tick();
    endtask

    initial begin
        logic [9:0] fr;
        logic [7:0] got;
        vecs[0] = '{2'b00, 8'hA5, 8'h00, 0, 1'b0, 10'h0A5};
        vecs[1] = '{2'b10, 8'h12, 8'h00, 0, 1'b0, 10'h212};
        vecs[2] = '{2'b11, 8'h00, 8'h3C, 0, 1'b0, 10'h300};
        vecs[3] = '{2'b11, 8'hFF, 8'h5A, 3, 1'b1, 10'h3FF};
        vecs[4] = '{2'b01, 8'h7E, 8'h00, 0, 1'b0, 10'h17E};
        vecs[5] = '{2'b10, 8'h81, 8'h00, 0, 1'b0, 10'h281};
        vecs[6] = '{2'b11, 8'h55, 8'hC3, 1, 1'b0, 10'h355};

        #1;
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_rx_data", {22'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_abort", {31'd0, frame_abort}, 32'd0);
        chk("rst_seq_err", {31'd0, seq_err}, 32'd0);
        tick(); rst = 1'b0; tick();

        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].cmd, vecs[v].pay, vecs[v].tx, vecs[v].dly, vecs[v].seq, vecs[v].rx);
        end

        // Abort after 5 payload bits, then a clean frame.
        fr = {2'b01, 8'hF0};
        ss_n = 1'b0; tick();
        for (int i = 0; i < 7; i++) begin mosi = fr[9-i]; tick(); end
        ss_n = 1'b1; tick();
        chk("abort_mid_recv", {31'd0, frame_abort}, 32'd1);
        tick();
        chk("abort_one_cycle", {31'd0, frame_abort}, 32'd0);
        chk("rx_data_kept", {22'd0, rx_data}, 32'h355);
        run_txn(2'b00, 8'h3B, 8'h00, 0, 1'b0, 10'h03B);

        // SS_n drops and rises before any data bit: no abort.
        ss_n = 1'b0; tick(); ss_n = 1'b1; tick();
        chk("no_abort_bitcnt0", {31'd0, frame_abort}, 32'd0);
        tick();

        // SS_n rises on the completing edge: abort wins, no rx_valid.
        fr = {2'b01, 8'h66};
        ss_n = 1'b0; tick();
        for (int i = 0; i < 9; i++) begin mosi = fr[9-i]; tick(); end
        mosi = fr[0]; ss_n = 1'b1; tick();
        chk("abort_on_last", {31'd0, frame_abort}, 32'd1);
        chk("no_valid_on_abort", {31'd0, rx_valid}, 32'd0);
        tick();
        chk("rx_data_kept2", {22'd0, rx_data}, 32'h03B);

        // Abort while waiting for tx_valid.
        run_txn(2'b10, 8'h01, 8'h00, 0, 1'b0, 10'h201);
        fr = {2'b11, 8'h02};
        sb.push_back('{10'h302, 1'b0});
        ss_n = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin mosi = fr[9-i]; tick(); end
        tick(); ss_n = 1'b1; tick();
        chk("abort_tx_wait", {31'd0, frame_abort}, 32'd1);
        tick();

        // Reset during TX_SHIFT with MISO high; reset alone must clear it.
        run_txn(2'b10, 8'h12, 8'h00, 0, 1'b0, 10'h212);
        fr = {2'b11, 8'h44};
        sb.push_back('{10'h344, 1'b0});
        tx_data = 8'h3C;
        ss_n = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin mosi = fr[9-i]; tick(); end
        tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        chk("miso_bit3_high", {31'd0, miso}, 32'd1);
        #2 rst = 1'b1; #1;
        chk("rst_async_miso", {31'd0, miso}, 32'd0);
        chk("rst_async_rx_data", {22'd0, rx_data}, 32'd0);
        ss_n = 1'b1; tick(); rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick(); chk("no_abort_after_rst", {31'd0, frame_abort}, 32'd0);
        end

        // Read-data straight after reset: seq_err, data still sent.
        run_txn(2'b11, 8'h00, 8'h3C, 0, 1'b1, 10'h300);

        // LSB-first instance: receive and transmit bit order.
        fr = {2'b01, 8'h01};
        ss_l = 1'b0; tick();
        mosi_l = 1'b0; tick(); mosi_l = 1'b1; tick();
        for (int i = 0; i < 8; i++) begin mosi_l = fr[i]; tick(); end
        chk("lsb_rx_valid", {31'd0, rx_valid_l}, 32'd1);
        chk("lsb_rx_data_101", {22'd0, rx_data_l}, 32'h101);
        ss_l = 1'b1; tick(); tick();
        fr = {2'b11, 8'hA5};
        tx_data_l = 8'h81 ^ 8'h40;
        ss_l = 1'b0; tick();
        mosi_l = 1'b1; tick(); mosi_l = 1'b1; tick();
        for (int i = 0; i < 8; i++) begin mosi_l = fr[i]; tick(); end
        chk("lsb_rx_data_3a5", {22'd0, rx_data_l}, 32'h3A5);
        chk("lsb_seq_err", {31'd0, seq_err_l}, 32'd1);
        tx_valid_l = 1'b1; tick(); got[0] = miso_l; tx_valid_l = 1'b0;
        for (int j = 1; j < 8; j++) begin tick(); got[j] = miso_l; end
        chk("lsb_miso_word", {24'd0, got}, 32'hC1);
        ss_l = 1'b1; tick(); tick();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
